// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words from instruction memory and
// hands them to decode over a valid/ready handshake, then forms the next PC.
module instr_fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] ins,
    output logic             ins_valid,
    input  logic             ins_ready,
    input  logic             pc_src,
    input  logic [WIDTH-1:0] imm_ext,
    output logic [WIDTH-1:0] pc,
    output logic             fetch_err,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_ERR
    } state_e;

    localparam int unsigned      CNT_W        = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]       ERR_NONE     = 2'b00;
    localparam logic [1:0]       ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0]       ERR_MISALIGN = 2'b10;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ins_q, ins_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [WIDTH-1:0] target;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ins_q      <= '0;
            cnt_q      <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ins_q      <= ins_d;
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ins_d      = ins_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;
        target     = pc_q + (pc_src ? imm_ext : WIDTH'(32'd4));

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response on the last allowed cycle still wins over the timeout
                if (imem_rvalid) begin
                    ins_d   = imem_rdata;
                    state_d = S_ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (ins_ready) begin
                    if (pc_src && (target[1:0] != 2'b00)) begin
                        err_code_d = ERR_MISALIGN;
                        state_d    = S_ERR;
                    end else begin
                        pc_d    = target;
                        state_d = S_REQ;
                    end
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req  = (state_q == S_REQ);
    assign ins_valid = (state_q == S_ISSUE);
    assign fetch_err = (state_q == S_ERR);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ins       = ins_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level PC/memory model, directed
// scenarios followed by randomized fetch/branch/stall traffic.
module tb_instr_fetch_unit;

    localparam int unsigned W   = 32;
    localparam int unsigned TO  = 16;
    localparam logic [31:0] RPC = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [W-1:0]  imem_addr;
    logic          imem_rvalid;
    logic [W-1:0]  imem_rdata;
    logic [W-1:0]  ins;
    logic          ins_valid;
    logic          ins_ready;
    logic          pc_src;
    logic [W-1:0]  imm_ext;
    logic [W-1:0]  pc;
    logic          fetch_err;
    logic [1:0]    err_code;

    int            n_total = 0;
    int            n_pass  = 0;
    int            n_fail  = 0;
    logic [31:0]   exp_pc;
    logic          erred;

    instr_fetch_unit #(.WIDTH(W), .RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .pc_src(pc_src), .imm_ext(imm_ext), .pc(pc),
        .fetch_err(fetch_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge; optionally a stale response lands in IDLE
    task automatic do_reset(input logic late_rsp);
        rst = 1'b1; imem_rvalid = 1'b0; ins_ready = 1'b0; pc_src = 1'b0;
        step();
        rst = 1'b0;
        check("rst_req",   32'(imem_req), 0);
        check("rst_valid", 32'(ins_valid), 0);
        check("rst_pc",    pc, RPC);
        check("rst_addr",  imem_addr, RPC);
        check("rst_ins",   ins, 0);
        check("rst_err",   32'(fetch_err), 0);
        check("rst_code",  32'(err_code), 0);
        imem_rvalid = late_rsp; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("post_rst_ins", ins, 0);
        exp_pc = RPC;
        erred  = 1'b0;
    endtask

    // One complete fetch: REQ, `delay` idle WAIT cycles, response, `stall` ISSUE cycles, accept
    task automatic fetch(input int delay, input int stall, input logic br, input logic [31:0] imm);
        logic [31:0] tgt;
        check("req",       32'(imem_req), 1);
        check("req_addr",  imem_addr, exp_pc);
        check("req_valid", 32'(ins_valid), 0);
        imem_rvalid = 1'($urandom % 2); imem_rdata = $urandom;
        step();
        for (int i = 0; i < delay; i++) begin
            imem_rvalid = 1'b0;
            check("wait_req", 32'(imem_req), 0);
            step();
        end
        imem_rvalid = 1'b1; imem_rdata = mem_word(exp_pc);
        step();
        check("iss_valid", 32'(ins_valid), 1);
        check("iss_ins",   ins, mem_word(exp_pc));
        check("iss_pc",    pc, exp_pc);
        check("iss_req",   32'(imem_req), 0);
        for (int i = 0; i < stall; i++) begin
            ins_ready = 1'b0; pc_src = 1'($urandom % 2); imm_ext = $urandom;
            imem_rvalid = 1'($urandom % 2); imem_rdata = $urandom;
            step();
            check("stall_valid", 32'(ins_valid), 1);
            check("stall_ins",   ins, mem_word(exp_pc));
            check("stall_pc",    pc, exp_pc);
            check("stall_req",   32'(imem_req), 0);
        end
        imem_rvalid = 1'b0;
        ins_ready = 1'b1; pc_src = br; imm_ext = imm;
        tgt = br ? exp_pc + imm : exp_pc + 32'd4;
        step();
        ins_ready = 1'b0; pc_src = 1'b0;
        if (br && (tgt[1:0] != 2'b00)) begin
            check("mis_err",  32'(fetch_err), 1);
            check("mis_code", 32'(err_code), 2);
            check("mis_pc",   pc, exp_pc);
            check("mis_req",  32'(imem_req), 0);
            erred = 1'b1;
        end else begin
            exp_pc = tgt;
        end
    endtask

    // ERR must absorb all inputs and keep its code
    task automatic hold_err(input logic [1:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            imem_rvalid = 1'($urandom % 2); imem_rdata = $urandom;
            ins_ready = 1'($urandom % 2); pc_src = 1'($urandom % 2); imm_ext = $urandom;
            step();
            check("err_flag",  32'(fetch_err), 1);
            check("err_code",  32'(err_code), 32'(code));
            check("err_req",   32'(imem_req), 0);
            check("err_valid", 32'(ins_valid), 0);
            check("err_pc",    pc, exp_pc);
        end
        imem_rvalid = 1'b0; ins_ready = 1'b0; pc_src = 1'b0;
    endtask

    task automatic timeout_run();
        check("to_req", 32'(imem_req), 1);
        step();
        for (int i = 0; i < int'(TO); i++) begin
            imem_rvalid = 1'b0;
            check("to_wait_err", 32'(fetch_err), 0);
            check("to_wait_req", 32'(imem_req), 0);
            step();
        end
        check("to_err",  32'(fetch_err), 1);
        check("to_code", 32'(err_code), 1);
        hold_err(2'b01, 4);
    endtask

    initial begin
        int          d;
        int          s;
        logic        br;
        logic [31:0] imm;
        rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        ins_ready = 1'b0; pc_src = 1'b0; imm_ext = '0;
        exp_pc = RPC; erred = 1'b0;

        do_reset(1'b0);
        // Sequential run 0,4,8,C at full throughput
        for (int i = 0; i < 4; i++) fetch(0, 0, 1'b0, 32'h0);
        check("seq_pc", pc, 32'h10);
        // Backward and forward taken branches from 0x10
        fetch(0, 0, 1'b1, 32'hFFFF_FFF8);
        check("br_back", imem_addr, 32'h08);
        fetch(0, 0, 1'b0, 32'h0);
        fetch(0, 0, 1'b0, 32'h0);
        fetch(0, 0, 1'b1, 32'h20);
        check("br_fwd", imem_addr, 32'h30);
        // Backpressure, then a response on the final allowed WAIT cycle
        fetch(2, 5, 1'b0, 32'h0);
        fetch(int'(TO) - 1, 0, 1'b0, 32'h0);
        check("late_ok_err", 32'(fetch_err), 0);
        // Wrap around the top of the address space
        fetch(0, 0, 1'b1, 32'hFFFF_FFFC - exp_pc);
        check("at_top", pc, 32'hFFFF_FFFC);
        fetch(1, 0, 1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0);
        // Misaligned branch target from 0x10
        fetch(0, 0, 1'b1, 32'h10);
        fetch(0, 0, 1'b1, 32'h6);
        check("mis_pc_hold", pc, 32'h10);
        hold_err(2'b10, 3);

        do_reset(1'b0);
        timeout_run();

        // Reset in the middle of WAIT with a stale response arriving in IDLE
        do_reset(1'b0);
        fetch(0, 0, 1'b0, 32'h0);
        check("pre_rst_req", 32'(imem_req), 1);
        step();
        step();
        do_reset(1'b1);
        fetch(0, 0, 1'b0, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            d   = int'($urandom_range(0, TO - 1));
            s   = int'($urandom_range(0, 3));
            br  = ($urandom % 3) == 0;
            imm = 32'($urandom_range(0, 64)) << 2;
            if ($urandom % 2 == 1) imm = -imm;
            if ($urandom % 8 == 0) imm[1:0] = 2'($urandom_range(1, 3));
            fetch(d, s, br, imm);
            if (erred) begin
                hold_err(2'b10, 2);
                do_reset(1'($urandom % 2));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
